// File: rtl/nave_ctrl.sv
// nave_ctrl: serve/play/pause sequencing and paddle motion for the breakout playfield.
// Motion is tick-paced, with a same-direction speed ramp and clamping at the screen edges.
module nave_ctrl #(
    parameter int TICK_DIV   = 416667,
    parameter int X_RESET    = 320,
    parameter int Y_NAVE     = 410,
    parameter int LARGURA    = 45,
    parameter int SCREEN_W   = 640,
    parameter int V_MIN      = 1,
    parameter int V_MAX      = 6,
    parameter int RAMP_TICKS = 8
) (
    input  logic       CLOCK_50,
    input  logic       resetNave,
    input  logic [3:0] keysout,
    input  logic       pausa,
    input  logic       bateu,
    input  logic       perdeu,
    input  logic [9:0] x_bola,
    output logic       iniciarBola,
    output logic [9:0] x_nave,
    output logic [9:0] y_nave,
    output logic [1:0] estado,
    output logic [2:0] velocidade,
    output logic [7:0] rebatidas
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = $clog2(RAMP_TICKS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_TICKS);

    typedef enum logic [1:0] {SERVE = 2'b00, PLAY = 2'b01, PAUSED = 2'b10} state_t;
    typedef enum logic [1:0] {DIR_NONE = 2'b00, DIR_RIGHT = 2'b01, DIR_LEFT = 2'b10} dir_t;

    state_t        state_q, state_d, ret_q, ret_d;
    dir_t          dir_prev_q, dir_prev_d, dir;
    logic          demo_q, demo_d;
    logic          ini_q, ini_d;
    logic [1:0]    key_hist_q, key_hist_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [RW-1:0] ramp_q, ramp_d, ramp_n;
    logic [9:0]    x_q, x_d;
    logic [2:0]    vel_q, vel_d, vel_n;
    logic [7:0]    hits_q, hits_d;

    logic          tick, serve_edge, demo_edge;
    logic [10:0]   x11, v11, center, bola, x_move;

    // Direction, ramped speed and clamped position that a tick would apply this cycle.
    always_comb begin
        tick       = (tick_q == TICK_LAST);
        serve_edge = keysout[2] & ~key_hist_q[0];
        demo_edge  = keysout[3] & ~key_hist_q[1];
        x11        = {1'b0, x_q};
        center     = x11 + 11'(LARGURA >> 1);
        bola       = {1'b0, x_bola};

        dir = DIR_NONE;
        if (demo_q) begin
            if (bola > center + 11'd2) begin
                dir = DIR_RIGHT;
            end else if (bola + 11'd2 < center) begin
                dir = DIR_LEFT;
            end
        end else if (keysout[0] & ~keysout[1]) begin
            dir = DIR_RIGHT;
        end else if (keysout[1] & ~keysout[0]) begin
            dir = DIR_LEFT;
        end

        ramp_n = '0;
        vel_n  = 3'(V_MIN);
        if (dir != DIR_NONE && dir == dir_prev_q) begin
            if (ramp_q + RW'(1) == RAMP_LAST) begin
                vel_n = (vel_q < 3'(V_MAX)) ? vel_q + 3'd1 : vel_q;
            end else begin
                ramp_n = ramp_q + RW'(1);
                vel_n  = vel_q;
            end
        end

        v11    = {8'd0, vel_n};
        x_move = x11;
        case (dir)
            DIR_RIGHT: x_move = (x11 + 11'(LARGURA) + v11 > 11'(SCREEN_W)) ?
                                11'(SCREEN_W - LARGURA) : x11 + v11;
            DIR_LEFT:  x_move = (x11 < v11) ? 11'd0 : x11 - v11;
            default:   x_move = x11;
        endcase
    end

    // Game flow: pausa dominates; a lost ball recentres even on a motion tick.
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        dir_prev_d = dir_prev_q;
        demo_d     = demo_q;
        ini_d      = 1'b0;
        key_hist_d = keysout[3:2];
        tick_d     = tick_q;
        ramp_d     = ramp_q;
        x_d        = x_q;
        vel_d      = vel_q;
        hits_d     = hits_q;

        if (state_q != PAUSED) begin
            tick_d = tick ? '0 : tick_q + TW'(1);
        end

        case (state_q)
            SERVE, PLAY: begin
                if (pausa) begin
                    state_d = PAUSED;
                    ret_d   = state_q;
                end else begin
                    if (demo_edge) begin
                        demo_d = ~demo_q;
                    end
                    if (tick) begin
                        x_d        = x_move[9:0];
                        vel_d      = vel_n;
                        ramp_d     = ramp_n;
                        dir_prev_d = dir;
                    end
                    if (state_q == SERVE && serve_edge) begin
                        state_d = PLAY;
                        ini_d   = 1'b1;
                    end
                    if (state_q == PLAY) begin
                        if (bateu && hits_q != 8'hFF) begin
                            hits_d = hits_q + 8'd1;
                        end
                        if (perdeu) begin
                            state_d    = SERVE;
                            x_d        = 10'(X_RESET);
                            vel_d      = 3'(V_MIN);
                            ramp_d     = '0;
                            hits_d     = '0;
                            dir_prev_d = DIR_NONE;
                        end
                    end
                end
            end
            PAUSED: begin
                if (!pausa) begin
                    state_d = ret_q;
                end
            end
            default: state_d = SERVE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge resetNave) begin
        if (resetNave) begin
            state_q    <= SERVE;
            ret_q      <= SERVE;
            dir_prev_q <= DIR_NONE;
            demo_q     <= 1'b0;
            ini_q      <= 1'b0;
            key_hist_q <= '0;
            tick_q     <= '0;
            ramp_q     <= '0;
            x_q        <= 10'(X_RESET);
            vel_q      <= 3'(V_MIN);
            hits_q     <= '0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            dir_prev_q <= dir_prev_d;
            demo_q     <= demo_d;
            ini_q      <= ini_d;
            key_hist_q <= key_hist_d;
            tick_q     <= tick_d;
            ramp_q     <= ramp_d;
            x_q        <= x_d;
            vel_q      <= vel_d;
            hits_q     <= hits_d;
        end
    end

    assign iniciarBola = ini_q;
    assign x_nave      = x_q;
    assign y_nave      = 10'(Y_NAVE);
    assign estado      = state_q;
    assign velocidade  = vel_q;
    assign rebatidas   = hits_q;
endmodule

// File: tb/tb_nave_ctrl.sv
// tb_nave_ctrl: directed scenarios for nave_ctrl with a scoreboard of expected paddle positions,
// popped by a monitor each time x_nave moves, plus direct status checks.
module tb_nave_ctrl;
    logic       CLOCK_50 = 1'b0;
    logic       resetNave;
    logic [3:0] keysout;
    logic       pausa, bateu, perdeu;
    logic [9:0] x_bola;
    logic       iniciarBola;
    logic [9:0] x_nave, y_nave;
    logic [1:0] estado;
    logic [2:0] velocidade;
    logic [7:0] rebatidas;

    int         n_checks = 0;
    int         n_fail = 0;
    int         n_ini_pulses = 0;
    int         ini_len = 0;
    logic [9:0] exp_x_q[$];
    logic [9:0] prev_x = 10'd320;

    nave_ctrl #(.TICK_DIV(4)) dut (
        .CLOCK_50(CLOCK_50), .resetNave(resetNave), .keysout(keysout), .pausa(pausa),
        .bateu(bateu), .perdeu(perdeu), .x_bola(x_bola), .iniciarBola(iniciarBola),
        .x_nave(x_nave), .y_nave(y_nave), .estado(estado), .velocidade(velocidade),
        .rebatidas(rebatidas)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Inputs change just after a rising edge and are held for the given number of cycles.
    task automatic applyStimulus(input logic [3:0] k, input logic p, input logic b,
                                 input logic l, input int cycles);
        keysout = k;
        pausa   = p;
        bateu   = b;
        perdeu  = l;
        repeat (cycles) begin
            @(posedge CLOCK_50);
            #2;
        end
    endtask

    // Expected positions of a run of ticks in one direction starting from rest (speed 1).
    task automatic pushRamp(input int start, input bit go_right, input int ball, input int max_steps);
        int x = start;
        int v = 1;
        int run = 0;
        int nx;
        for (int i = 0; i < max_steps; i++) begin
            if (ball >= 0 && (x + 22 - ball) <= 2 && (ball - (x + 22)) <= 2) break;
            if (go_right) nx = (x + 45 + v > 640) ? 595 : x + v;
            else          nx = (x < v) ? 0 : x - v;
            if (nx == x) break;
            x = nx;
            exp_x_q.push_back(10'(x));
            run++;
            if (run == 8) begin
                run = 0;
                if (v < 6) v++;
            end
        end
    endtask

    task automatic waitQueueEmpty(input string name, input int budget);
        int n = 0;
        while (exp_x_q.size() != 0 && n < budget) begin
            @(posedge CLOCK_50);
            #2;
            n++;
        end
        checkOutput(name, exp_x_q.size(), 0);
    endtask

    always @(negedge CLOCK_50) begin
        if (x_nave !== prev_x) begin
            if (exp_x_q.size() == 0) checkOutput("x_unexpected_move", int'(x_nave), int'(prev_x));
            else                     checkOutput("x_step", int'(x_nave), int'(exp_x_q.pop_front()));
            prev_x = x_nave;
        end
        if (iniciarBola === 1'b1) begin
            ini_len++;
        end else if (ini_len != 0) begin
            n_ini_pulses++;
            checkOutput("ini_width", ini_len, 1);
            ini_len = 0;
        end
    end

    initial begin
        resetNave = 1'b1;
        keysout   = '0;
        pausa     = 1'b0;
        bateu     = 1'b0;
        perdeu    = 1'b0;
        x_bola    = 10'd100;
        repeat (3) @(posedge CLOCK_50);
        #2;
        resetNave = 1'b0;

        applyStimulus(4'b0000, 0, 0, 0, 20);
        checkOutput("reset_x", int'(x_nave), 320);
        checkOutput("reset_y", int'(y_nave), 410);
        checkOutput("reset_estado", int'(estado), 0);
        checkOutput("reset_ini", int'(iniciarBola), 0);
        checkOutput("reset_vel", int'(velocidade), 1);
        checkOutput("reset_hits", int'(rebatidas), 0);

        applyStimulus(4'b0100, 0, 0, 0, 1);
        checkOutput("serve_ini", int'(iniciarBola), 1);
        checkOutput("serve_estado", int'(estado), 1);
        applyStimulus(4'b0100, 0, 0, 0, 1);
        checkOutput("serve_ini_fall", int'(iniciarBola), 0);
        applyStimulus(4'b0100, 0, 0, 0, 10);
        checkOutput("serve_held_ini", int'(iniciarBola), 0);

        pushRamp(320, 1'b1, -1, 200);
        applyStimulus(4'b0001, 0, 0, 0, 0);
        waitQueueEmpty("right_ramp_done", 400);
        applyStimulus(4'b0001, 0, 0, 0, 40);
        checkOutput("right_clamp_x", int'(x_nave), 595);
        checkOutput("right_vel_sat", int'(velocidade), 6);

        pushRamp(595, 1'b0, -1, 200);
        applyStimulus(4'b0010, 0, 0, 0, 0);
        waitQueueEmpty("left_ramp_done", 700);
        applyStimulus(4'b0010, 0, 0, 0, 40);
        checkOutput("left_clamp_x", int'(x_nave), 0);

        pushRamp(0, 1'b1, -1, 26);
        applyStimulus(4'b0001, 0, 0, 0, 0);
        waitQueueEmpty("right_26_done", 200);
        checkOutput("vel_before_turn", int'(velocidade), 4);
        exp_x_q.push_back(10'd55);
        applyStimulus(4'b0010, 0, 0, 0, 0);
        waitQueueEmpty("turn_done", 20);
        checkOutput("vel_after_turn", int'(velocidade), 1);
        applyStimulus(4'b0011, 0, 0, 0, 20);
        checkOutput("both_keys_x", int'(x_nave), 55);
        checkOutput("both_keys_vel", int'(velocidade), 1);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0000, 0, 1, 0, 1);
            applyStimulus(4'b0000, 0, 0, 0, 1);
        end
        checkOutput("hits_three", int'(rebatidas), 3);

        applyStimulus(4'b0000, 1, 0, 0, 5);
        checkOutput("pause_estado", int'(estado), 2);
        applyStimulus(4'b0000, 1, 0, 1, 1);
        applyStimulus(4'b0000, 1, 0, 0, 5);
        applyStimulus(4'b0100, 1, 0, 0, 1);
        applyStimulus(4'b0000, 1, 0, 0, 5);
        applyStimulus(4'b0000, 1, 1, 0, 1);
        applyStimulus(4'b0000, 1, 0, 0, 32);
        checkOutput("pause_estado_held", int'(estado), 2);
        checkOutput("pause_x_frozen", int'(x_nave), 55);
        checkOutput("pause_hits", int'(rebatidas), 3);
        applyStimulus(4'b0000, 0, 0, 0, 1);
        checkOutput("resume_estado", int'(estado), 1);
        applyStimulus(4'b0000, 0, 0, 0, 10);
        checkOutput("resume_still_play", int'(estado), 1);

        exp_x_q.push_back(10'd320);
        applyStimulus(4'b0000, 0, 0, 1, 1);
        checkOutput("lost_estado", int'(estado), 0);
        checkOutput("lost_x", int'(x_nave), 320);
        checkOutput("lost_hits", int'(rebatidas), 0);
        checkOutput("lost_vel", int'(velocidade), 1);
        applyStimulus(4'b0000, 0, 0, 0, 10);

        pushRamp(320, 1'b0, 100, 200);
        applyStimulus(4'b1000, 0, 0, 0, 1);
        applyStimulus(4'b0000, 0, 0, 0, 0);
        waitQueueEmpty("demo_track_done", 400);
        applyStimulus(4'b0000, 0, 0, 0, 20);
        checkOutput("demo_hold_x", int'(x_nave), 80);
        applyStimulus(4'b0001, 0, 0, 0, 20);
        checkOutput("demo_ignores_keys", int'(x_nave), 80);
        checkOutput("demo_hold_vel", int'(velocidade), 1);

        applyStimulus(4'b0100, 0, 0, 0, 1);
        checkOutput("reserve_estado", int'(estado), 1);
        applyStimulus(4'b0000, 0, 1, 0, 1);
        applyStimulus(4'b0000, 0, 0, 0, 1);
        checkOutput("rally_hits", int'(rebatidas), 1);
        exp_x_q.push_back(10'd320);
        #3;
        resetNave = 1'b1;
        #1;
        checkOutput("async_reset_x", int'(x_nave), 320);
        checkOutput("async_reset_estado", int'(estado), 0);
        checkOutput("async_reset_hits", int'(rebatidas), 0);
        checkOutput("async_reset_vel", int'(velocidade), 1);
        checkOutput("async_reset_ini", int'(iniciarBola), 0);
        repeat (2) @(posedge CLOCK_50);
        #2;
        resetNave = 1'b0;
        applyStimulus(4'b0000, 0, 0, 0, 12);
        checkOutput("after_reset_x", int'(x_nave), 320);

        checkOutput("ini_pulse_count", n_ini_pulses, 2);
        checkOutput("x_queue_drained", exp_x_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
